// File: rtl/log_merger_pkg.sv
// Shared definitions for the log stream merger: FSM states, header layout
// and a helper that assembles the 64-bit header beat.
package log_merger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_PASS   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_MAGIC = 8'hA5;
  localparam logic [7:0] SRC_ID_A     = 8'h00;
  localparam logic [7:0] SRC_ID_B     = 8'h01;

  localparam int HDR_W         = 64;
  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_SRC_LSB   = 48;
  localparam int HDR_SEQ_LSB   = 0;
  localparam int HDR_SEQ_W     = 32;

  // Header: magic | source id | 16'h0 | sequence number
  function automatic logic [HDR_W-1:0] make_header(input logic src_b,
                                                   input logic [HDR_SEQ_W-1:0] seq);
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 8]       = HEADER_MAGIC;
    hdr[HDR_SRC_LSB +: 8]         = src_b ? SRC_ID_B : SRC_ID_A;
    hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/log_rr_arbiter.sv
// Two-way round-robin packet arbiter. The grant output is combinational;
// the merger samples it only while idle. last_grant resets to B so that
// source A wins the first tie.
module log_rr_arbiter
  import log_merger_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  input  logic done_grant_b,
  output logic grant_b
);

  logic last_grant_b;

  // Remember which source completed the most recent packet
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_b <= 1'b1;
    end else if (done) begin
      last_grant_b <= done_grant_b;
    end
  end

  // A lone requester wins outright; a tie goes to the source that did not win last
  always_comb begin
    grant_b = req_b;
    if (req_a && req_b) begin
      grant_b = !last_grant_b;
    end
  end

endmodule

// File: rtl/log_stream_merger.sv
// Merges two AXI4-Stream log sources into one, packet by packet in
// round-robin order, prefixing each packet with a header beat that carries
// the source ID and a per-source sequence number.
// Optional stall timeout: define LOG_STREAM_MERGER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no packet granted; arbitrate when enable=1
// HEADER | registered header beat waits for m_axis_log_tready
// PASS   | granted source passes straight through to the output
// FLUSH  | after a timeout, silently drain the source up to its tlast
module log_stream_merger
  import log_merger_pkg::*;
#(
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
  input  logic                        s_axis_log_a_tlast,
  input  logic                        s_axis_log_a_tvalid,
  output logic                        s_axis_log_a_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
  input  logic                        s_axis_log_b_tlast,
  input  logic                        s_axis_log_b_tvalid,
  output logic                        s_axis_log_b_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
  output logic                        m_axis_log_tlast,
  output logic                        m_axis_log_tvalid,
  input  logic                        m_axis_log_tready,
  output logic [15:0]                 timeout_count
);

  localparam int W = C_AXIS_LOG_WIDTH;

  state_t          state;
  logic            grant_b;
  logic            arb_grant_b;
  logic [31:0]     seq_a;
  logic [31:0]     seq_b;
  logic [W-1:0]    out_tdata;
  logic            out_tlast;
  logic            out_tvalid;
  logic            to_beat;
  logic            flush_done;
  logic [W-1:0]    sel_tdata;
  logic            sel_tlast;
  logic            sel_tvalid;
  logic            pass_live;
  logic            src_hs;
  logic            pkt_done;

`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(C_TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] stall_left;
  logic [15:0]      timeout_count_r;

  assign flush_done    = (state == ST_FLUSH) && sel_tvalid && sel_tlast;
  assign timeout_count = timeout_count_r;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (C_TIMEOUT_CYCLES > 1);
  assign to_beat            = 1'b0;
  assign flush_done         = 1'b0;
  assign timeout_count      = 16'h0000;
`endif

  assign sel_tdata  = grant_b ? s_axis_log_b_tdata  : s_axis_log_a_tdata;
  assign sel_tlast  = grant_b ? s_axis_log_b_tlast  : s_axis_log_a_tlast;
  assign sel_tvalid = grant_b ? s_axis_log_b_tvalid : s_axis_log_a_tvalid;

  // The timeout beat borrows PASS but comes from the output register
  assign pass_live = (state == ST_PASS) && !to_beat;
  assign src_hs    = pass_live && sel_tvalid && m_axis_log_tready;
  assign pkt_done  = (src_hs && sel_tlast) || flush_done;

  log_rr_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_a        (s_axis_log_a_tvalid),
    .req_b        (s_axis_log_b_tvalid),
    .done         (pkt_done),
    .done_grant_b (grant_b),
    .grant_b      (arb_grant_b)
  );

  // Output mux: pass-through in PASS, registered beat everywhere else
  always_comb begin
    m_axis_log_tdata    = out_tdata;
    m_axis_log_tlast    = out_tlast;
    m_axis_log_tvalid   = out_tvalid;
    s_axis_log_a_tready = 1'b0;
    s_axis_log_b_tready = 1'b0;
    if (pass_live) begin
      m_axis_log_tdata  = sel_tdata;
      m_axis_log_tlast  = sel_tlast;
      m_axis_log_tvalid = sel_tvalid;
      if (grant_b) s_axis_log_b_tready = m_axis_log_tready;
      else         s_axis_log_a_tready = m_axis_log_tready;
    end
`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
    if (state == ST_FLUSH) begin
      if (grant_b) s_axis_log_b_tready = 1'b1;
      else         s_axis_log_a_tready = 1'b1;
    end
`endif
  end

  // Per-source sequence numbers advance once per finished (or flushed) packet
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_a <= '0;
      seq_b <= '0;
    end else if (pkt_done) begin
      if (grant_b) seq_b <= seq_b + 32'd1;
      else         seq_a <= seq_a + 32'd1;
    end
  end

  // Packet sequencing FSM with registered header / timeout beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_b    <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
      to_beat         <= 1'b0;
      stall_left      <= '0;
      timeout_count_r <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && (s_axis_log_a_tvalid || s_axis_log_b_tvalid)) begin
            grant_b    <= arb_grant_b;
            out_tdata  <= W'(make_header(arb_grant_b, arb_grant_b ? seq_b : seq_a));
            out_tlast  <= 1'b0;
            out_tvalid <= 1'b1;
            state      <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (m_axis_log_tready) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            state      <= ST_PASS;
`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
            stall_left <= TMO_LOAD;
`endif
          end
        end
        ST_PASS: begin
`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
          if (to_beat) begin
            if (m_axis_log_tready) begin
              to_beat    <= 1'b0;
              out_tvalid <= 1'b0;
              out_tlast  <= 1'b0;
              out_tdata  <= '0;
              if (timeout_count_r != 16'hFFFF) begin
                timeout_count_r <= timeout_count_r + 16'd1;
              end
              state <= ST_FLUSH;
            end
          end else if (pkt_done) begin
            state <= ST_IDLE;
          end else if (src_hs) begin
            stall_left <= TMO_LOAD;
          end else if (!sel_tvalid) begin
            if (stall_left == TMO_ONE) begin
              to_beat    <= 1'b1;
              out_tdata  <= '1;
              out_tlast  <= 1'b1;
              out_tvalid <= 1'b1;
            end else begin
              stall_left <= stall_left - TMO_ONE;
            end
          end
`else
          if (pkt_done) begin
            state <= ST_IDLE;
          end
`endif
        end
`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
        ST_FLUSH: begin
          if (pkt_done) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_stream_merger.sv
// Scoreboard bench for log_stream_merger: source driver processes feed
// beats from per-source queues, expected output beats are queued when
// stimulus is issued, and a monitor pops and compares on every handshake.
module tb_log_stream_merger;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           gap;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] s_a_tdata, s_b_tdata;
  logic         s_a_tlast, s_b_tlast;
  logic         s_a_tvalid, s_b_tvalid;
  logic         s_a_tready, s_b_tready;
  logic [W-1:0] m_tdata;
  logic         m_tlast, m_tvalid;
  logic         m_tready;
  logic [15:0]  timeout_count;

  beat_t a_q[$];
  beat_t b_q[$];
  beat_t exp_q[$];

  int  errors = 0;
  int  checks = 0;
  bit  rand_rdy = 1'b0;
  bit  rdy_fixed = 1'b1;

  log_stream_merger #(
    .C_AXIS_LOG_WIDTH (W),
    .C_TIMEOUT_CYCLES (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .s_axis_log_a_tdata  (s_a_tdata),
    .s_axis_log_a_tlast  (s_a_tlast),
    .s_axis_log_a_tvalid (s_a_tvalid),
    .s_axis_log_a_tready (s_a_tready),
    .s_axis_log_b_tdata  (s_b_tdata),
    .s_axis_log_b_tlast  (s_b_tlast),
    .s_axis_log_b_tvalid (s_b_tvalid),
    .s_axis_log_b_tready (s_b_tready),
    .m_axis_log_tdata    (m_tdata),
    .m_axis_log_tlast    (m_tlast),
    .m_axis_log_tvalid   (m_tvalid),
    .m_axis_log_tready   (m_tready),
    .timeout_count       (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [W-1:0] d, input logic l, input int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    a_q.push_back(b);
  endtask

  task automatic push_b(input logic [W-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l; b.gap = 0;
    b_q.push_back(b);
  endtask

  task automatic expect_beat(input logic [W-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l; b.gap = 0;
    exp_q.push_back(b);
  endtask

  task automatic wait_exp(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timed out with %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_all(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() + a_q.size() + b_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((exp_q.size() + a_q.size() + b_q.size()) != 0) begin
      errors++;
      $display("FAIL %s: timed out, exp=%0d a=%0d b=%0d left, required 0",
               name, exp_q.size(), a_q.size(), b_q.size());
    end
  endtask

  // Source A driver: present queue front, pop after each handshake, honour gaps
  initial begin : drv_a
    bit fire;
    s_a_tvalid = 1'b0; s_a_tdata = '0; s_a_tlast = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_a_tvalid && s_a_tready;
      @(posedge clk);
      #1;
      if (fire && a_q.size() > 0) void'(a_q.pop_front());
      if (a_q.size() > 0 && a_q[0].gap > 0) begin
        a_q[0].gap = a_q[0].gap - 1;
        s_a_tvalid = 1'b0;
      end else if (a_q.size() > 0) begin
        s_a_tvalid = 1'b1; s_a_tdata = a_q[0].d; s_a_tlast = a_q[0].l;
      end else begin
        s_a_tvalid = 1'b0;
      end
    end
  end

  // Source B driver
  initial begin : drv_b
    bit fire;
    s_b_tvalid = 1'b0; s_b_tdata = '0; s_b_tlast = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_b_tvalid && s_b_tready;
      @(posedge clk);
      #1;
      if (fire && b_q.size() > 0) void'(b_q.pop_front());
      if (b_q.size() > 0) begin
        s_b_tvalid = 1'b1; s_b_tdata = b_q[0].d; s_b_tlast = b_q[0].l;
      end else begin
        s_b_tvalid = 1'b0;
      end
    end
  end

  // Downstream ready: fixed level or random backpressure
  initial begin : drv_rdy
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: hold-stability under backpressure and in-order beat compare
  initial begin : mon
    bit           pend;
    logic [W-1:0] pend_d;
    logic         pend_l;
    beat_t        e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_valid", W'(m_tvalid), W'(1'b1));
          chk("hold_data", m_tdata, pend_d);
          chk("hold_last", W'(m_tlast), W'(pend_l));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h last=%0b, required no beat", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.d);
            chk("beat_last", W'(m_tlast), W'(e.l));
          end
        end
        pend   = m_tvalid && !m_tready;
        pend_d = m_tdata;
        pend_l = m_tlast;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    enable = 1'b1;
    rdy_fixed = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", W'(m_tvalid), '0);
    chk("rst_m_tlast", W'(m_tlast), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_a_tready", W'(s_a_tready), '0);
    chk("rst_b_tready", W'(s_b_tready), '0);
    chk("rst_timeout_count", W'(timeout_count), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: three-beat packet on A
    push_a(64'd1, 1'b0, 0); push_a(64'd2, 1'b0, 0); push_a(64'd3, 1'b1, 0);
    expect_beat(64'hA500_0000_0000_0000, 1'b0);
    expect_beat(64'd1, 1'b0); expect_beat(64'd2, 1'b0); expect_beat(64'd3, 1'b1);
    wait_all("t1_drain", 100);

    // 2: fresh reset, A and B contend for four rounds
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    push_a(64'hAA10, 1'b0, 0); push_a(64'hAA11, 1'b1, 0);
    push_a(64'hAA20, 1'b0, 0); push_a(64'hAA21, 1'b1, 0);
    push_b(64'hBB10, 1'b0); push_b(64'hBB11, 1'b1);
    push_b(64'hBB20, 1'b0); push_b(64'hBB21, 1'b1);
    expect_beat(64'hA500_0000_0000_0000, 1'b0);
    expect_beat(64'hAA10, 1'b0); expect_beat(64'hAA11, 1'b1);
    expect_beat(64'hA501_0000_0000_0000, 1'b0);
    expect_beat(64'hBB10, 1'b0); expect_beat(64'hBB11, 1'b1);
    expect_beat(64'hA500_0000_0000_0001, 1'b0);
    expect_beat(64'hAA20, 1'b0); expect_beat(64'hAA21, 1'b1);
    expect_beat(64'hA501_0000_0000_0001, 1'b0);
    expect_beat(64'hBB20, 1'b0); expect_beat(64'hBB21, 1'b1);
    wait_all("t2_drain", 200);

    // 3: four-beat packet on B under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 4; i++) push_b(64'hB300 + 64'(i), 1'(i == 3));
    expect_beat(64'hA501_0000_0000_0002, 1'b0);
    for (int i = 0; i < 4; i++) expect_beat(64'hB300 + 64'(i), 1'(i == 3));
    wait_all("t3_drain", 500);
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // 4a: enable drops mid-packet; the pending A packet waits for enable
    push_a(64'hC1, 1'b0, 0); push_a(64'hC2, 1'b0, 0); push_a(64'hC3, 1'b1, 0);
    push_a(64'hD1, 1'b0, 0); push_a(64'hD2, 1'b1, 0);
    expect_beat(64'hA500_0000_0000_0002, 1'b0);
    expect_beat(64'hC1, 1'b0); expect_beat(64'hC2, 1'b0); expect_beat(64'hC3, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 3 && n < 100) begin @(negedge clk); n++; end
    end
    enable = 1'b0;
    wait_exp("t4_first_pkt", 100);
    repeat (8) @(negedge clk);
    chk("t4_hold_m_tvalid", W'(m_tvalid), '0);
    chk("t4_hold_a_tready", W'(s_a_tready), '0);
    expect_beat(64'hA500_0000_0000_0003, 1'b0);
    expect_beat(64'hD1, 1'b0); expect_beat(64'hD2, 1'b1);
    enable = 1'b1;
    wait_all("t4_second_pkt", 100);

    // 6: one-beat B packet and an A packet arrive together; B wins the tie
    push_b(64'hE1, 1'b1);
    push_a(64'hF1, 1'b0, 0); push_a(64'hF2, 1'b1, 0);
    expect_beat(64'hA501_0000_0000_0003, 1'b0);
    expect_beat(64'hE1, 1'b1);
    expect_beat(64'hA500_0000_0000_0004, 1'b0);
    expect_beat(64'hF1, 1'b0); expect_beat(64'hF2, 1'b1);
    wait_all("t6_drain", 100);

    // 4b: reset mid-packet clears every output on the next cycle
    for (int i = 0; i < 4; i++) push_a(64'h9900 + 64'(i), 1'(i == 3), 0);
    expect_beat(64'hA500_0000_0000_0005, 1'b0);
    for (int i = 0; i < 4; i++) expect_beat(64'h9900 + 64'(i), 1'(i == 3));
    begin
      int n;
      n = 0;
      while (exp_q.size() > 3 && n < 100) begin @(negedge clk); n++; end
    end
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    a_q.delete();
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4b_m_tvalid", W'(m_tvalid), '0);
    chk("t4b_m_tlast", W'(m_tlast), '0);
    chk("t4b_m_tdata", m_tdata, '0);
    chk("t4b_a_tready", W'(s_a_tready), '0);
    chk("t4b_b_tready", W'(s_b_tready), '0);
    @(posedge clk); #1; rst = 1'b0;
    rdy_fixed = 1'b1;
    repeat (3) @(negedge clk);

`ifdef LOG_STREAM_MERGER_TIMEOUT_EN
    // 5: A stalls after its first beat; timeout beat then silent flush
    push_a(64'h51, 1'b0, 0); push_a(64'h52, 1'b0, 6);
    push_a(64'h53, 1'b0, 0); push_a(64'h54, 1'b1, 0);
    expect_beat(64'hA500_0000_0000_0000, 1'b0);
    expect_beat(64'h51, 1'b0);
    expect_beat({W{1'b1}}, 1'b1);
    wait_all("t5_drain", 200);
    chk("t5_timeout_count", W'(timeout_count), W'(16'd1));
    push_b(64'h61, 1'b1);
    expect_beat(64'hA501_0000_0000_0000, 1'b0);
    expect_beat(64'h61, 1'b1);
    wait_all("t5_after", 100);
`else
    chk("timeout_count_off", W'(timeout_count), '0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log_stream_merger.md
Name: log_stream_merger

Overview:
- Sits directly downstream of eth_frame_detector's two log outputs (M_AXIS_LOG_A, M_AXIS_LOG_B).
- Merges both log streams into one AXI4-Stream towards the DMA/log FIFO.
- Arbitrates per packet in round-robin order, never interleaving beats of different packets.
- Prefixes every forwarded packet with one header beat that carries the source ID and a per-source sequence number.

Parameters:
- C_AXIS_LOG_WIDTH, 64, data width of all stream ports; legal values are ≥64 and a multiple of 8.
- C_TIMEOUT_CYCLES, 1024, stall limit for the optional timeout feature; legal values are ≥2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new packet is granted; a packet already in flight still completes.
- s_axis_log_a_tdata  in  C_AXIS_LOG_WIDTH  source A data.
- s_axis_log_a_tlast  in  1  source A end of packet.
- s_axis_log_a_tvalid  in  1  source A valid.
- s_axis_log_a_tready  out  1  source A ready.
- s_axis_log_b_tdata / _tlast / _tvalid / _tready  same widths and directions as source A, for source B.
- m_axis_log_tdata  out  C_AXIS_LOG_WIDTH  merged output data.
- m_axis_log_tlast  out  1  merged end of packet.
- m_axis_log_tvalid  out  1  merged valid.
- m_axis_log_tready  in  1  merged ready.
- timeout_count  out  16  saturating count of timed-out packets; only meaningful with the optional feature, otherwise tied to 0.

Behaviour:
- Reset values:
  - state = IDLE; last_grant = B, so A wins the first tie; seq_a = seq_b = 0.
  - m_axis_log_tvalid = 0, tlast = 0, tdata = 0.
  - Both s_*_tready = 0; timeout_count = 0.
- Reset has priority over everything. Reset mid-packet abandons the packet: no tlast is emitted, and the downstream side is expected to be reset together with this block.
- FSM states: IDLE, HEADER, PASS, plus FLUSH with the optional feature.
- IDLE:
  - Both s_*_tready = 0 and m tvalid = 0.
  - If enable=1 and at least one source tvalid=1, latch grant: the only requester, or, when both request, the source other than last_grant. Go to HEADER.
  - Arbitration takes exactly one cycle; IDLE always lasts at least one cycle.
- HEADER (registered beat):
  - m tvalid = 1, tlast = 0.
  - tdata[63:56] = 8'hA5, [55:48] = source ID (A = 0, B = 1), [47:32] = 0, [31:0] = seq of the granted source; bits above 63 = 0.
  - Holds stable until m_tready=1, then goes to PASS. Source tready stays 0 during HEADER.
- PASS (combinational pass-through of the granted source only):
  - m tdata/tlast/tvalid = granted s tdata/tlast/tvalid; granted s tready = m_tready; the other source's tready = 0.
  - On a handshake with tlast=1: increment that source's seq (wraps modulo 2^32), last_grant = grant, go to IDLE.
- enable falling during HEADER or PASS has no effect until the FSM returns to IDLE.
- A one-beat source packet (tvalid and tlast together on the first beat) produces exactly two output beats: header, then data with tlast.
- Output throughput: one beat per cycle within a packet. Overhead is two cycles per packet (IDLE + HEADER) when m_tready is held at 1.
- Data beats are never dropped or reordered, except under the optional feature below.

Optional Feature:
- Macro: LOG_STREAM_MERGER_TIMEOUT_EN.
- Defined:
  - In PASS, a counter increments on every cycle where the granted tvalid=0 and clears on every beat accepted from the source.
  - When it reaches C_TIMEOUT_CYCLES, the block emits one beat from a register: tdata = all-ones, tlast = 1. This beat waits for m_tready; the source is held with tready = 0 meanwhile.
  - timeout_count then increments, saturating at 16'hFFFF, and the FSM enters FLUSH.
  - FLUSH: granted s tready = 1 and m tvalid = 0; the rest of the source packet is discarded up to and including its tlast beat. Then seq increments, last_grant updates, and the FSM goes to IDLE.
- Undefined: no counter and no FLUSH state; a stalled source blocks the merger indefinitely; timeout_count = 0.

Decomposition:
- Shared package log_merger_pkg:
  - state enum (IDLE, HEADER, PASS, FLUSH).
  - HEADER_MAGIC = 8'hA5, SRC_ID_A = 0, SRC_ID_B = 1.
  - header field bit positions.
- One natural sub-module: log_rr_arbiter, covering request inputs, last_grant register, and grant output.

Test Plan:
1. After reset, a 3-beat packet on A only (data 1, 2, 3) with m_tready=1 -> output A5000000_00000000, 1, 2, 3; tlast only on 3; seq_a becomes 1.
2. A and B both valid in the same cycle, each sending 2 beats, repeated for 4 rounds -> grant order A, B, A, B; B headers show seq 0, 1.
3. Toggle m_tready randomly during a 4-beat packet on B -> every beat is held stable while tready=0; no duplicated or lost beats; the header reads A5010000_0000000N.
4. Drop enable during PASS -> the current packet completes; a pending A packet is not granted until enable=1; assert rst mid-packet -> all outputs are 0 on the next cycle.
5. Feature on, C_TIMEOUT_CYCLES=4: A stalls for 4 cycles after beat 1 -> an all-ones beat with tlast is emitted, the remaining A beats up to tlast are consumed silently, timeout_count = 1.
6. One-beat packet on B with tlast on the first beat -> exactly 2 output beats; the next IDLE grants a waiting A.
